game_ctrl_fsm: RTL

Parametrised successor to the top-level game controller. Holds the four-screen menu FSM (start, info, choose count, game), the selectable object count and the game cursor. It also holds NUM_OBJ wrap-around object counters that advance on an internal tick, with per-object sticky alarm bits. It sits between the matrix-key scanner (btn bus) and the display, segment and buzzer logic.

---
 rtl/game_ctrl_fsm_if.sv | 29 ++
 rtl/game_ctrl_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm_if.sv
// Key/display bus between the matrix-key scanner, the game controller and the
// display/segment/buzzer logic. Parameters must match the game_ctrl_fsm instance.
interface game_ctrl_fsm_if #(
    parameter int NUM_OBJ = 10,
    parameter int CNT_W   = 4
) ();
    localparam int SEL_W = $clog2(NUM_OBJ + 1);
    localparam int CUR_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    logic [15:0]            btn;
    logic [1:0]             state;
    logic [SEL_W-1:0]       sel_num;
    logic [CUR_W-1:0]       cursor;
    logic [NUM_OBJ*CNT_W-1:0] counters;
    logic [NUM_OBJ-1:0]     alarm_vec;
    logic                   buzz;
    logic                   tick;
    logic                   paused;

    // master: key scanner / display side; slave: the controller
    modport master (
        output btn,
        input  state, sel_num, cursor, counters, alarm_vec, buzz, tick, paused
    );
    modport slave (
        input  btn,
        output state, sel_num, cursor, counters, alarm_vec, buzz, tick, paused
    );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Menu FSM, object count, cursor and ticking object counters with sticky alarms.
// Optional pause feature enabled by defining GAME_CTRL_PAUSE_EN.
module game_ctrl_fsm #(
    parameter int NUM_OBJ  = 10,
    parameter int CNT_W    = 4,
    parameter int CNT_WRAP = 10,
    parameter int TICK_DIV = 50000000
) (
    input logic            clk,
    input logic            rst,
    game_ctrl_fsm_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_OBJ + 1);
    localparam int CUR_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] WRAP_M1 = CNT_W'(CNT_WRAP - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_OBJ);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_INFO   = 2'd1,
        S_CHOOSE = 2'd2,
        S_GAME   = 2'd3
    } state_t;

    state_t                r_state;
    logic [15:0]           r_btn_q;
    logic [SEL_W-1:0]      r_sel;
    logic [CUR_W-1:0]      r_cursor;
    logic [CNT_W-1:0]      r_cnt [NUM_OBJ];
    logic [NUM_OBJ-1:0]    r_alarm;
    logic                  r_buzz;
    logic                  r_tick;
    logic                  r_paused;
    logic [PRE_W-1:0]      r_presc;

    logic [15:0]              w_ev;
    logic                     w_up;
    logic                     w_dn;
    logic                     w_tick_now;
    logic [CUR_W-1:0]         w_cur_max;
    logic [NUM_OBJ*CNT_W-1:0] w_counters;
    logic                     w_unused;

    assign w_ev       = bus.btn & ~r_btn_q;
    assign w_up       = w_ev[2] | w_ev[5];
    assign w_dn       = w_ev[6] | w_ev[7];
    assign w_cur_max  = CUR_W'(r_sel - SEL_W'(1));
    assign w_tick_now = (r_state == S_GAME) && !r_paused && (r_presc == PRE_MAX);
    assign w_unused   = ^{w_ev[9:8], w_ev[4:3], w_ev[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_START;
            r_btn_q  <= '0;
            r_sel    <= SEL_W'(1);
            r_cursor <= '0;
            for (int i = 0; i < NUM_OBJ; i++) r_cnt[i] <= '0;
            r_alarm  <= '0;
            r_buzz   <= 1'b0;
            r_tick   <= 1'b0;
            r_paused <= 1'b0;
            r_presc  <= '0;
        end else begin
            r_btn_q <= bus.btn;
            r_buzz  <= |r_alarm;
            r_tick  <= 1'b0;
            case (r_state)
                S_START: begin
                    if (w_ev[14])      r_state <= S_CHOOSE;
                    else if (w_ev[15]) r_state <= S_INFO;
                end
                S_INFO: begin
                    if (w_ev[13])      r_state <= S_START;
                    else if (w_ev[14]) r_state <= S_CHOOSE;
                end
                S_CHOOSE: begin
                    if (w_ev[12]) begin
                        r_state <= S_START;
                    end else if (w_ev[14]) begin
                        r_state  <= S_GAME;
                        for (int i = 0; i < NUM_OBJ; i++)
                            r_cnt[i] <= (i < int'(r_sel)) ? CNT_W'(1) : '0;
                        r_alarm  <= '0;
                        r_cursor <= '0;
                        r_presc  <= '0;
                        r_paused <= 1'b0;
                    end else if (w_ev[11]) begin
                        r_sel <= (r_sel == SEL_MAX) ? SEL_W'(1) : r_sel + SEL_W'(1);
                    end
                end
                S_GAME: begin
                    if (w_ev[12]) begin
                        r_state  <= S_START;
                        for (int i = 0; i < NUM_OBJ; i++) r_cnt[i] <= '0;
                        r_alarm  <= '0;
                        r_presc  <= '0;
                        r_paused <= 1'b0;
                    end else begin
                        // a frozen prescaler resumes from where it stopped
                        if (!r_paused) begin
                            if (w_tick_now) begin
                                r_presc <= '0;
                                r_tick  <= 1'b1;
                            end else begin
                                r_presc <= r_presc + PRE_W'(1);
                            end
                        end
                        if (w_up && !w_dn)
                            r_cursor <= (r_cursor == w_cur_max) ? '0 : r_cursor + CUR_W'(1);
                        else if (w_dn && !w_up)
                            r_cursor <= (r_cursor == '0) ? w_cur_max : r_cursor - CUR_W'(1);
                        // confirm on the cursor object overrides a coincident tick
                        for (int i = 0; i < NUM_OBJ; i++) begin
                            if (w_ev[10] && (i == int'(r_cursor))) begin
                                r_cnt[i]   <= CNT_W'(1);
                                r_alarm[i] <= 1'b0;
                            end else if (w_tick_now && (i < int'(r_sel))) begin
                                if (r_cnt[i] == WRAP_M1) begin
                                    r_cnt[i]   <= '0;
                                    r_alarm[i] <= 1'b1;
                                end else begin
                                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                                end
                            end
                        end
`ifdef GAME_CTRL_PAUSE_EN
                        if (w_ev[11]) r_paused <= ~r_paused;
`endif
                    end
                end
                default: r_state <= S_START;
            endcase
        end
    end

    always_comb begin
        w_counters = '0;
        for (int i = 0; i < NUM_OBJ; i++) w_counters[i*CNT_W +: CNT_W] = r_cnt[i];
    end

    assign bus.state     = r_state;
    assign bus.sel_num   = r_sel;
    assign bus.cursor    = r_cursor;
    assign bus.counters  = w_counters;
    assign bus.alarm_vec = r_alarm;
    assign bus.buzz      = r_buzz;
    assign bus.tick      = r_tick;
    assign bus.paused    = r_paused;
endmodule
